// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: writeback source select, load funct3
// encodings and the MEM/WB pipeline register payload.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 64;

  // Writeback source; WB_RSVD is decoded the same as WB_ALU.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  // Load funct3 encodings; anything else is treated as a word load.
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // MEM/WB pipeline register contents.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [REG_AW-1:0] rd;
    wb_sel_e           wb_sel;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   rdata;
    logic [XLEN-1:0]   pc_plus4;
  } mem_wb_t;

  // True for the loads that access a single byte or halfword.
  function automatic logic is_half_load(input logic [2:0] f3);
    return (f3 == F3_LH) || (f3 == F3_LHU);
  endfunction

  function automatic logic is_byte_load(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LBU);
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: extracts the addressed byte/halfword from an aligned
// memory word and sign- or zero-extends it to XLEN.
//   rdata       - raw aligned memory word
//   offset      - byte offset within the word (address[1:0])
//   funct3      - load type
//   load_data_c - aligned and extended load result (combinational)
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_data_c
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Byte lane select; halfword uses only offset[1].
  always_comb begin
    byte_val = 8'h00;
    unique case (offset)
      2'd0: byte_val = rdata[7:0];
      2'd1: byte_val = rdata[15:8];
      2'd2: byte_val = rdata[23:16];
      2'd3: byte_val = rdata[31:24];
      default: byte_val = rdata[7:0];
    endcase
    half_val = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension by load type; undefined encodings behave as LW.
  always_comb begin
    load_data_c = rdata;
    unique case (funct3)
      F3_LB:   load_data_c = {{(XLEN-8){byte_val[7]}}, byte_val};
      F3_LBU:  load_data_c = {{(XLEN-8){1'b0}}, byte_val};
      F3_LH:   load_data_c = {{(XLEN-16){half_val[15]}}, half_val};
      F3_LHU:  load_data_c = {{(XLEN-16){1'b0}}, half_val};
      default: load_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: captures the MEM-stage instruction, then drives the
// register-file write port, misaligned-load trap and retired-instruction count.
//   clk, rst                - clock, synchronous active-high reset
//   mem_*                   - MEM-stage instruction fields
//   stall, flush            - hold the register / insert a bubble (flush wins)
//   rf_reg_write/addr/data  - register-file write port (decoded from register)
//   wb_valid, misalign_trap - retiring this cycle / load misaligned
//   instret                 - retired-instruction counter (registered)
module mem_wb_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [1:0]        mem_wb_sel,
  input  logic [XLEN-1:0]   mem_alu_result,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic [XLEN-1:0]   mem_pc_plus4,
  input  logic [2:0]        mem_funct3,
  input  logic              stall,
  input  logic              flush,
  output logic              rf_reg_write,
  output logic [REG_AW-1:0] rf_write_addr,
  output logic [XLEN-1:0]   rf_write_data,
  output logic              wb_valid,
  output logic              misalign_trap,
  output logic [CNT_W-1:0]  instret
);

  mem_wb_t           wb_q;
  mem_wb_t           wb_d;
  logic [CNT_W-1:0]  instret_q;
  logic [XLEN-1:0]   load_data;
  logic [1:0]        offset;

  // Pack MEM-stage inputs into the register payload.
  always_comb begin
    wb_d            = '0;
    wb_d.valid      = mem_valid;
    wb_d.reg_write  = mem_reg_write;
    wb_d.rd         = mem_rd;
    wb_d.wb_sel     = wb_sel_e'(mem_wb_sel);
    wb_d.funct3     = mem_funct3;
    wb_d.alu_result = mem_alu_result;
    wb_d.rdata      = mem_rdata;
    wb_d.pc_plus4   = mem_pc_plus4;
  end

  // MEM/WB register: reset > flush > stall > capture. Flush drops only valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
    end else if (flush) begin
      wb_q.valid <= 1'b0;
    end else if (!stall) begin
      wb_q <= wb_d;
    end
  end

  assign offset = wb_q.alu_result[1:0];

  load_align u_load_align (
    .rdata       (wb_q.rdata),
    .offset      (offset),
    .funct3      (wb_q.funct3),
    .load_data_c (load_data)
  );

  // Trap and retire decode from the captured instruction.
  always_comb begin
    misalign_trap = 1'b0;
    if (wb_q.valid && (wb_q.wb_sel == WB_LOAD)) begin
      if (is_half_load(wb_q.funct3)) begin
        misalign_trap = offset[0];
      end else if (!is_byte_load(wb_q.funct3)) begin
        misalign_trap = (offset != 2'd0);
      end
    end
    wb_valid     = wb_q.valid & ~misalign_trap;
    rf_reg_write = wb_valid & wb_q.reg_write & (wb_q.rd != REG_AW'(0));
  end

  // Writeback data select; reserved encoding falls through to ALU.
  always_comb begin
    rf_write_data = wb_q.alu_result;
    unique case (wb_q.wb_sel)
      WB_LOAD: rf_write_data = load_data;
      WB_PC4:  rf_write_data = wb_q.pc_plus4;
      default: rf_write_data = wb_q.alu_result;
    endcase
  end

  assign rf_write_addr = wb_q.rd;

  // Count on the edge the retiring instruction leaves WB, so a stalled
  // instruction is counted exactly once. Wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (wb_valid && !stall) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: load alignment, traps, stall/flush,
// rd=0 writes, counter wrap and mid-stream reset.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_rdata;
  logic [31:0] mem_pc_plus4;
  logic [2:0]  mem_funct3;
  logic        stall;
  logic        flush;
  logic        rf_reg_write;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        wb_valid;
  logic        misalign_trap;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  mem_wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd         (mem_rd),
    .mem_wb_sel     (mem_wb_sel),
    .mem_alu_result (mem_alu_result),
    .mem_rdata      (mem_rdata),
    .mem_pc_plus4   (mem_pc_plus4),
    .mem_funct3     (mem_funct3),
    .stall          (stall),
    .flush          (flush),
    .rf_reg_write   (rf_reg_write),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data),
    .wb_valid       (wb_valid),
    .misalign_trap  (misalign_trap),
    .instret        (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_rd         = rd;
    mem_wb_sel     = sel;
    mem_funct3     = f3;
    mem_alu_result = alu;
    mem_rdata      = rdata;
    mem_pc_plus4   = pc4;
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic rw, input logic [4:0] addr,
                        input logic [31:0] data, input logic v, input logic trap,
                        input logic [63:0] cnt);
    chk({tag, ".rf_reg_write"}, 64'(rf_reg_write), 64'(rw));
    chk({tag, ".rf_write_addr"}, 64'(rf_write_addr), 64'(addr));
    chk({tag, ".rf_write_data"}, 64'(rf_write_data), 64'(data));
    chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(v));
    chk({tag, ".misalign_trap"}, 64'(misalign_trap), 64'(trap));
    chk({tag, ".instret"}, instret, cnt);
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b1, 1'b1, 5'd9, 2'd1, 3'd2, 32'h1002, 32'hFFFF_FFFF, 32'h4);
    step();
    step();
    chk_wb("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 64'd0);

    rst = 1'b0;
    // LB offset 3 of 0x80FF7F01 -> 0x80 sign-extended
    drive(1'b1, 1'b1, 5'd5, 2'd1, 3'd0, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
    step();
    chk_wb("lb_off3", 1'b1, 5'd5, 32'hFFFF_FF80, 1'b1, 1'b0, 64'd0);

    // LHU offset 2 -> 0x80FF zero-extended
    drive(1'b1, 1'b1, 5'd6, 2'd1, 3'd5, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
    step();
    chk_wb("lhu_off2", 1'b1, 5'd6, 32'h0000_80FF, 1'b1, 1'b0, 64'd1);

    // LH offset 2 -> 0x80FF sign-extended
    drive(1'b1, 1'b1, 5'd7, 2'd1, 3'd1, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
    step();
    chk_wb("lh_off2", 1'b1, 5'd7, 32'hFFFF_80FF, 1'b1, 1'b0, 64'd2);

    // LBU offset 3 -> 0x80 zero-extended
    drive(1'b1, 1'b1, 5'd8, 2'd1, 3'd4, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
    step();
    chk_wb("lbu_off3", 1'b1, 5'd8, 32'h0000_0080, 1'b1, 1'b0, 64'd3);

    // Misaligned LW at 0x1002: trap, no write, not counted
    drive(1'b1, 1'b1, 5'd9, 2'd1, 3'd2, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
    step();
    chk("lw_mis.misalign_trap", 64'(misalign_trap), 64'd1);
    chk("lw_mis.rf_reg_write", 64'(rf_reg_write), 64'd0);
    chk("lw_mis.wb_valid", 64'(wb_valid), 64'd0);
    chk("lw_mis.instret", instret, 64'd4);

    // ALU write to rd=0: retires but no register write
    drive(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'h0000_1234, 32'h0, 32'h0);
    step();
    chk_wb("alu_rd0", 1'b0, 5'd0, 32'h0000_1234, 1'b1, 1'b0, 64'd4);

    // JAL writes PC+4, then held through a 3-cycle stall
    drive(1'b1, 1'b1, 5'd1, 2'd2, 3'd0, 32'h0000_DEAD, 32'h0, 32'h0000_0104);
    step();
    chk_wb("jal", 1'b1, 5'd1, 32'h0000_0104, 1'b1, 1'b0, 64'd5);
    stall = 1'b1;
    drive(1'b1, 1'b1, 5'd2, 2'd0, 3'd0, 32'h0000_BEEF, 32'h0, 32'h0);
    step();
    chk_wb("stall1", 1'b1, 5'd1, 32'h0000_0104, 1'b1, 1'b0, 64'd5);
    step();
    chk_wb("stall2", 1'b1, 5'd1, 32'h0000_0104, 1'b1, 1'b0, 64'd5);
    step();
    chk_wb("stall3", 1'b1, 5'd1, 32'h0000_0104, 1'b1, 1'b0, 64'd5);
    stall = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    step();
    chk("stall_release.instret", instret, 64'd6);
    chk("stall_release.wb_valid", 64'(wb_valid), 64'd0);

    // Flush together with stall -> bubble, rd retained
    drive(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 32'h0000_0055, 32'h0, 32'h0);
    step();
    chk_wb("pre_flush", 1'b1, 5'd3, 32'h0000_0055, 1'b1, 1'b0, 64'd6);
    stall = 1'b1;
    flush = 1'b1;
    step();
    chk_wb("flush_stall", 1'b0, 5'd3, 32'h0000_0055, 1'b0, 1'b0, 64'd6);
    stall = 1'b0;
    flush = 1'b0;

    // Reserved wb_sel behaves as ALU
    drive(1'b1, 1'b1, 5'd4, 2'd3, 3'd0, 32'h0000_CAFE, 32'h1111_1111, 32'h2222_2222);
    step();
    chk_wb("wbsel_rsvd", 1'b1, 5'd4, 32'h0000_CAFE, 1'b1, 1'b0, 64'd6);

    // Undefined funct3=7 load, aligned -> full word
    drive(1'b1, 1'b1, 5'd10, 2'd1, 3'd7, 32'h0000_2000, 32'h80FF_7F01, 32'h0);
    step();
    chk_wb("f3_undef", 1'b1, 5'd10, 32'h80FF_7F01, 1'b1, 1'b0, 64'd7);

    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    step();
    chk("idle.instret", instret, 64'd8);

    // Preload the counter to all ones and retire one instruction
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    chk("preload.instret", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b1, 1'b1, 5'd11, 2'd0, 3'd0, 32'h0000_0011, 32'h0, 32'h0);
    step();
    chk("wrap_pre.instret", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_pre.wb_valid", 64'(wb_valid), 64'd1);
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    step();
    chk("wrap.instret", instret, 64'd0);

    // Reset mid-stream during a stall
    drive(1'b1, 1'b1, 5'd12, 2'd0, 3'd0, 32'h0000_0012, 32'h0, 32'h0);
    step();
    drive(1'b1, 1'b1, 5'd13, 2'd0, 3'd0, 32'h0000_0013, 32'h0, 32'h0);
    step();
    chk_wb("pre_rst", 1'b1, 5'd13, 32'h0000_0013, 1'b1, 1'b0, 64'd1);
    stall = 1'b1;
    rst   = 1'b1;
    step();
    chk_wb("mid_rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 64'd0);
    rst   = 1'b0;
    stall = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    step();
    chk("post_rst.wb_valid", 64'(wb_valid), 64'd0);
    chk("post_rst.instret", instret, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port mem_valid, input, 1, MEM stage holds a real instruction.
REQ-004 SHALL have port mem_reg_write, input, 1, instruction writes rd.
REQ-005 SHALL have port mem_rd, input, 5, destination register.
REQ-006 SHALL have port mem_wb_sel, input, 2, writeback source: 0 ALU, 1 load, 2 PC+4, 3 reserved (treated as ALU).
REQ-007 SHALL have ports mem_alu_result, mem_rdata and mem_pc_plus4, input, 32 each: ALU result (also load address), raw aligned memory word, and PC+4.
REQ-008 SHALL have port mem_funct3, input, 3, load type: LB=0, LH=1, LW=2, LBU=4, LHU=5.
REQ-009 SHALL have ports stall and flush, input, 1 each: hold the MEM/WB register, or insert a bubble.
REQ-010 SHALL have ports rf_reg_write (1), rf_write_addr (5) and rf_write_data (32), output, register-file write port.
REQ-011 SHALL have ports wb_valid (1), misalign_trap (1) and instret (64), output: retiring this cycle, load misaligned, retired-instruction count.

Function
REQ-012 SHALL capture all mem_* inputs into the MEM/WB register on each rising edge when stall=0 and flush=0.
REQ-013 SHALL hold register contents unchanged when stall=1 and flush=0.
REQ-014 SHALL clear the captured valid bit when flush=1; flush wins over stall.
REQ-015 SHALL drive all outputs except instret combinationally from the MEM/WB register, so an instruction reaches the register file one edge after capture.
REQ-016 SHALL select write data by captured wb_sel: ALU result, aligned load data, or PC+4.
REQ-017 SHALL align loads using captured alu_result[1:0] as byte offset: LB/LBU pick byte offset*8, LH/LHU pick halfword offset[1]*16, LW the whole word.
REQ-018 SHALL sign-extend LB/LH results and zero-extend LBU/LHU results to 32 bits.
REQ-019 SHALL treat a load with an undefined funct3 (3, 6 or 7) as LW.
REQ-020 SHALL assert misalign_trap when the captured instruction is valid, has wb_sel=load, and is LH/LHU with offset[0]=1 or LW with offset!=0.
REQ-021 SHALL assert rf_reg_write only when valid=1, reg_write=1, rd!=0 and misalign_trap=0.
REQ-022 SHALL drive rf_write_addr from the captured rd at all times.
REQ-023 SHALL drive wb_valid = valid & ~misalign_trap.
REQ-024 SHALL increment instret by 1 on each edge where wb_valid=1 and stall=0, wrapping from 2^64-1 to 0.
REQ-025 SHALL count an instruction once only, even if it is held for several stalled cycles.

Reset
REQ-026 SHALL, on an edge with rst=1, clear valid, reg_write, rd, wb_sel and all data fields to 0 and clear instret to 0.
REQ-027 SHALL give reset priority over stall and flush, including mid-stall.
REQ-028 SHALL hold rf_reg_write=0, wb_valid=0 and misalign_trap=0 in the cycle after reset.

Structure
REQ-029 SHALL take the wb_sel enum and the load funct3 constants from the shared package riscv_pkg.
REQ-030 SHALL place the combinational byte/halfword extraction and extension in one sub-module, load_align.

Verification
REQ-031 SHALL cover LB: rdata=0x80FF7F01, offset 3, rd=5 -> next cycle rf_reg_write=1, addr=5, data=0xFFFFFF80.
REQ-032 SHALL cover LHU: same word, offset 2 -> data=0x000080FF.
REQ-033 SHALL cover a misaligned LW at address 0x1002 -> misalign_trap=1, rf_reg_write=0, instret unchanged.
REQ-034 SHALL cover stall and flush: JAL with pc_plus4=0x104, then stall=1 for 3 cycles -> outputs held and instret +1 only once; flush=1 together with stall=1 -> bubble, wb_valid=0.
REQ-035 SHALL cover ALU write to rd=0 -> rf_reg_write=0 and wb_valid=1.
REQ-036 SHALL cover instret preloaded to 0xFFFF_FFFF_FFFF_FFFF with one retirement -> 0; rst asserted mid-stream -> all outputs 0 on the next cycle.
